// File: rtl/aes_block_feeder.sv
// Front end for a 10-round unrolled AES-128 core: packs 32-bit words into key and plaintext
// blocks, tracks launched blocks through the core latency and buffers ciphertext in a FIFO.
module aes_block_feeder #(
  parameter int unsigned CORE_LATENCY = 10,
  parameter int unsigned OUT_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_is_key,
  output logic         s_ready,
  output logic [127:0] blk_data,
  output logic [127:0] blk_key,
  input  logic [127:0] core_ct,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         key_loaded
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
  localparam logic [CntW:0]   CreditMax = (CntW + 1)'(OUT_DEPTH);
  localparam logic [CntW-1:0] CntMax    = CntW'(OUT_DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(OUT_DEPTH - 1);

  logic                    ready_q;
  logic [1:0]              beat_q, beat_d;
  logic                    is_key_q, is_key_d;
  logic [95:0]             shadow_q, shadow_d;
  logic [127:0]            blk_data_q, blk_data_d;
  logic [127:0]            blk_key_q, blk_key_d;
  logic                    key_loaded_q, key_loaded_d;
  logic [CORE_LATENCY-1:0] lat_q, lat_d;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [127:0]            mem_q [OUT_DEPTH];

  logic          grp_is_key;
  logic          last_beat;
  logic [CntW:0] credit_used;
  logic          credit_ok;
  logic          accept;
  logic          launch;
  logic          key_done;
  logic          capture;
  logic          pop;

  // Group type comes straight from the input on beat 0, from the latched copy afterwards.
  assign grp_is_key  = (beat_q == 2'd0) ? s_is_key : is_key_q;
  assign last_beat   = (beat_q == 2'd3);
  assign credit_used = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign credit_ok   = (credit_used < CreditMax);

  // Only the launching beat can stall; a pop in the same cycle does not free a credit.
  assign s_ready  = ready_q && !(last_beat && !grp_is_key && !credit_ok);
  assign accept   = s_valid && s_ready;
  assign launch   = accept && last_beat && !grp_is_key;
  assign key_done = accept && last_beat && grp_is_key;
  assign capture  = lat_q[CORE_LATENCY-1];
  assign pop      = m_valid && m_ready;

  assign blk_data   = blk_data_q;
  assign blk_key    = blk_key_q;
  assign key_loaded = key_loaded_q;
  assign m_valid    = (cnt_q != '0);
  assign m_data     = mem_q[rd_ptr_q];

  always_comb begin
    beat_d       = beat_q;
    is_key_d     = is_key_q;
    shadow_d     = shadow_q;
    blk_data_d   = blk_data_q;
    blk_key_d    = blk_key_q;
    key_loaded_d = key_loaded_q;

    if (accept) begin
      beat_d   = beat_q + 2'd1;
      shadow_d = {shadow_q[63:0], s_data};
      if (beat_q == 2'd0) begin
        is_key_d = s_is_key;
      end
    end
    if (key_done) begin
      blk_key_d    = {shadow_q, s_data};
      key_loaded_d = 1'b1;
    end
    if (launch) begin
      blk_data_d = {shadow_q, s_data};
    end
  end

  always_comb begin
    lat_d    = lat_q << 1;
    lat_d[0] = launch;

    inflight_d = inflight_q;
    case ({launch, capture})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase

    cnt_d = cnt_q;
    case ({capture, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (capture) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      beat_q       <= 2'd0;
      is_key_q     <= 1'b0;
      shadow_q     <= '0;
      blk_data_q   <= '0;
      blk_key_q    <= '0;
      key_loaded_q <= 1'b0;
      lat_q        <= '0;
      inflight_q   <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      ready_q      <= 1'b1;
      beat_q       <= beat_d;
      is_key_q     <= is_key_d;
      shadow_q     <= shadow_d;
      blk_data_q   <= blk_data_d;
      blk_key_q    <= blk_key_d;
      key_loaded_q <= key_loaded_d;
      lat_q        <= lat_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture) begin
      mem_q[wr_ptr_q] <= core_ct;
    end
  end

  // The credit check bounds in-flight plus buffered blocks, so a capture never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    capture |-> (cnt_q != CntMax));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= CreditMax);

endmodule
